// File: rtl/uart_rx_sampler.sv
// UART receive front end: 2-FF synchroniser, mid-bit sampler, 8N1 (8E1 with UART_RX_SAMPLER_PARITY_EN) framer.
// Latency: word/word_on_line (or frame_err) register one cycle after the stop-bit sample.
// Backpressure: none; word is held until the next good frame overwrites it.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       word_on_line,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_SAMPLER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic          rxd_m, rxd_s, rxd_d;
  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [2:0]    bit_q, bit_nx;
  logic [7:0]    sh_q, sh_nx;
  logic [7:0]    word_nx;
  logic          wol_nx, ferr_nx;
  logic          par_good;

`ifdef UART_RX_SAMPLER_PARITY_EN
  logic par_ok_q, par_ok_nx;
  assign par_good = par_ok_q;
`else
  assign par_good = 1'b1;
`endif

  // Synchroniser and edge register reset to the idle level so a low line at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      word         <= 8'h00;
      word_on_line <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_SAMPLER_PARITY_EN
      par_ok_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_nx;
      cnt_q        <= cnt_nx;
      bit_q        <= bit_nx;
      sh_q         <= sh_nx;
      word         <= word_nx;
      word_on_line <= wol_nx;
      frame_err    <= ferr_nx;
`ifdef UART_RX_SAMPLER_PARITY_EN
      par_ok_q     <= par_ok_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + CW'(1);
    bit_nx   = bit_q;
    sh_nx    = sh_q;
    word_nx  = word;
    wol_nx   = 1'b0;
    ferr_nx  = 1'b0;
`ifdef UART_RX_SAMPLER_PARITY_EN
    par_ok_nx = par_ok_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (rxd_d && !rxd_s) state_nx = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_nx = '0;
          if (rxd_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            bit_nx   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_nx = '0;
          sh_nx  = {rxd_s, sh_q[7:1]};
          bit_nx = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_SAMPLER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_SAMPLER_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_nx    = '0;
          par_ok_nx = ((^sh_q) == rxd_s);
          state_nx  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rxd_s && par_good) begin
            word_nx = sh_q;
            wol_nx  = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receive front end for the echo path. Synchronises the raw `rxd` pin, finds start bits, samples each bit at mid-bit, and assembles 8N1 frames (8E1 when parity is compiled in). Each valid byte is presented on `word` with a one-cycle `word_on_line` strobe, which the echo controller uses to start a transmit. Framing faults raise `frame_err` instead, and `word` is left unchanged.

## Interface
- `CLKS_PER_BIT`, 868 — clock cycles per bit (100 MHz / 115200). Legal range ≥ 4; counter width is `$clog2(CLKS_PER_BIT)`.
- `clk` input 1 — system clock; all logic on the rising edge.
- `rst` input 1 — reset, asynchronous, active-low.
- `rxd` input 1 — raw serial line; idles high; asynchronous to `clk`.
- `word` output 8 — last correctly received byte; held until the next good frame.
- `word_on_line` output 1 — one-cycle strobe; `word` is valid and new in that cycle.
- `frame_err` output 1 — one-cycle strobe; stop bit (or parity) failed.
- `busy` output 1 — high whenever the FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-FF synchroniser to give `rxd_s`. A third register `rxd_d` holds the previous `rxd_s` for edge detection.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** a falling edge (`rxd_d`=1, `rxd_s`=0) clears the counter and moves to START. A line held low (e.g. after a break) never re-arms until it has gone high.
- **START:** counts to `CLKS_PER_BIT/2 - 1` (integer division), then samples.
  - `rxd_s`=1: false start; return to IDLE, no strobe.
  - `rxd_s`=0: clear the counter and go to DATA with bit index 0.
- **DATA:** samples every `CLKS_PER_BIT` cycles. Bits shift in LSB first. After bit 7, go to PARITY, or to STOP when parity is not compiled in.
- **PARITY:** samples after `CLKS_PER_BIT` cycles and records the result of the even-parity check.
- **STOP:** samples after `CLKS_PER_BIT` cycles.
  - Stop = 1 and parity OK: load `word` from the shift register and pulse `word_on_line`.
  - Otherwise: pulse `frame_err` and leave `word` unchanged.
  - In both cases go to IDLE in the same cycle. The next falling edge is accepted immediately, so there is no dead time and back-to-back frames are supported.
- `word_on_line` and `frame_err` are mutually exclusive and never assert for more than one cycle.
- No back-pressure. The consumer must take `word` within one frame time, or the value is overwritten.

## Timing
- Reset values:
  - `word`=8'h00, `word_on_line`=0, `frame_err`=0, `busy`=0.
  - FSM=IDLE, counter=0.
  - Synchroniser and `rxd_d` reset to 1 (idle line), so reset release with the line low produces no false edge.
- Let E be the first cycle with `rxd_s`=0 after `rxd_s`=1. E is 2–3 cycles after the pin falls.
- Sample points:
  - Start sample at E + `CLKS_PER_BIT/2`.
  - Data bit i at E + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
  - Stop sample at E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- `word`, `word_on_line` and `frame_err` are registered and assert in the cycle after the stop sample.
- `busy` rises in cycle E+1 and falls together with the strobe.
- Reset asserted mid-frame: everything returns immediately to the reset values. A partially received byte is discarded and produces no strobe.

## Configuration
- `UART_RX_SAMPLER_PARITY_EN` defined:
  - The PARITY state is compiled in, and frames are 8E1.
  - A parity mismatch gives `frame_err` in place of `word_on_line`, with `word` unchanged.
- Not defined:
  - PARITY does not exist, and frames are 8N1.
  - The stop bit directly follows data bit 7.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Single byte:** reset, then drive 0xA5 as 8N1 at 16 cycles/bit → `word`=0xA5 and `word_on_line` high for exactly one cycle, at E+153 (E + 8 + 9·16 + 1). `frame_err` stays 0.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap → two strobes 160 cycles apart, with `word`=0x00 then 0xFF.
- **Glitch rejection:** pulse `rxd` low for 4 cycles → no strobe on either output, `busy` back to 0 within 10 cycles, and a following 0x3C is received correctly.
- **Framing error:** send 0x5A with the stop bit driven 0 → `frame_err` pulses once, `word` keeps its prior value, and no `word_on_line`. Then hold `rxd` low for 40 cycles, release it, and send 0x11 → exactly one `word_on_line` with 0x11.
- **Reset mid-frame:** assert `rst` during data bit 3 → outputs are at reset values the same cycle. Release reset and send 0x81 → `word`=0x81.
- **Parity (with `UART_RX_SAMPLER_PARITY_EN`):** send 0x07 with parity bit 1 → `word_on_line`. Resend with parity bit 0 → `frame_err` and `word` unchanged.
